stopwatch_counter: RTL and testbench

- Timekeeping core of the stopwatch. Turns button inputs into a running BCD count in SS.cc format (00.00 to 59.99).
- Drives the 16-bit digit bus that the 4-digit seven-segment scan driver consumes directly.
- Owns the start/pause/clear/lap control FSM, the 100 Hz prescaler and the BCD carry chain.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/stopwatch_counter_button_pulse.sv | 32 +++
 rtl/stopwatch_counter.sv | 146 ++++++++++++++
 tb/tb_stopwatch_counter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
//   state_t      : control FSM states (IDLE / RUN / PAUSE)
//   bcd4_t       : one BCD display digit
//   TICK_HZ      : default count rate (hundredths of a second)
//   DIGIT_MAX    : last value of a 0-9 digit
//   TENS_SEC_MAX : last value of the tens-of-seconds digit
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd4_t;

    localparam int    TICK_HZ      = 100;
    localparam bcd4_t DIGIT_MAX    = 4'd9;
    localparam bcd4_t TENS_SEC_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_counter_button_pulse.sv
// Button front end: 2-flop synchronizer followed by an edge register.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   level : debounced button level, asynchronous to clk
//   pulse : one-cycle pulse per rising edge of level (combinational from flops)
module button_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= level;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Pulse is visible after the 2nd edge, so the FSM acts on the 3rd edge.
    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: SS.cc BCD count (00.00 .. 59.99) with
// start/pause/clear/lap control.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   start_stop : button level, toggles RUN / PAUSE
//   clear      : button level, returns to IDLE from IDLE or PAUSE
//   lap        : button level, freezes / unfreezes the displayed value
//   digit      : registered BCD word {tens s, s, tenths, hundredths}
//   running    : high while the FSM is in RUN
//   lap_active : high while the displayed value is frozen
//   wrap       : one-cycle pulse on rollover 59.99 -> 00.00
//
// state | meaning
// IDLE  | stopped and zeroed, waiting for start
// RUN   | prescaler and BCD chain advancing
// PAUSE | count and partial prescaler held, resumable
module stopwatch_counter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = stopwatch_pkg::TICK_HZ
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] digit,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);
    import stopwatch_pkg::*;

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic ss_p;
    logic clear_p;
    logic lap_p;

    button_pulse u_ss    (.clk(clk), .rst(rst), .level(start_stop), .pulse(ss_p));
    button_pulse u_clear (.clk(clk), .rst(rst), .level(clear),      .pulse(clear_p));
    button_pulse u_lap   (.clk(clk), .rst(rst), .level(lap),        .pulse(lap_p));

    state_t        state;
    logic [PW-1:0] presc;
    bcd4_t         c3, c2, c1, c0;
    bcd4_t         n3, n2, n1, n0;
    logic [15:0]   snap;
    logic [15:0]   count_word;
    logic          tick;
    logic          at_max;

    assign count_word = {c3, c2, c1, c0};
    assign tick       = (state == RUN) && (presc == PRESC_LAST);
    assign at_max     = (c3 == TENS_SEC_MAX) && (c2 == DIGIT_MAX) &&
                        (c1 == DIGIT_MAX) && (c0 == DIGIT_MAX);

    // Ripple carry through the four digits; tens of seconds rolls at 5.
    always_comb begin
        n0 = c0 + 4'd1;
        n1 = c1;
        n2 = c2;
        n3 = c3;
        if (c0 == DIGIT_MAX) begin
            n0 = '0;
            n1 = c1 + 4'd1;
            if (c1 == DIGIT_MAX) begin
                n1 = '0;
                n2 = c2 + 4'd1;
                if (c2 == DIGIT_MAX) begin
                    n2 = '0;
                    n3 = (c3 == TENS_SEC_MAX) ? '0 : c3 + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            {c3, c2, c1, c0} <= '0;
            snap       <= '0;
            lap_active <= 1'b0;
            digit      <= '0;
            running    <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            wrap  <= 1'b0;
            digit <= lap_active ? snap : count_word;
            unique case (state)
                IDLE: begin
                    if (clear_p) begin
                        presc      <= '0;
                        {c3, c2, c1, c0} <= '0;
                        snap       <= '0;
                        lap_active <= 1'b0;
                    end else if (ss_p) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        {c3, c2, c1, c0} <= {n3, n2, n1, n0};
                        wrap <= at_max;
                    end
                    // Snapshot takes the pre-tick count of this same cycle.
                    if (lap_p) begin
                        lap_active <= ~lap_active;
                        if (!lap_active)
                            snap <= count_word;
                    end
                    // Start/stop beats clear here: clear is not decoded in RUN.
                    if (ss_p) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (clear_p) begin
                        state      <= IDLE;
                        presc      <= '0;
                        {c3, c2, c1, c0} <= '0;
                        snap       <= '0;
                        lap_active <= 1'b0;
                    end else begin
                        if (lap_p)
                            lap_active <= 1'b0;
                        if (ss_p) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

    localparam int DIV    = 10;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PAUSE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] digit;
    logic        running;
    logic        lap_active;
    logic        wrap;

    int n_vec = 0;
    int n_err = 0;

    stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .digit      (digit),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: count kept as integer hundredths, displayed via decimal split.
    function automatic logic [15:0] to_bcd(input int h);
        return {4'(h / 1000), 4'((h / 100) % 10), 4'((h / 10) % 10), 4'(h % 10)};
    endfunction

    int          m_st = S_IDLE;
    int          m_cnt = 0;
    int          m_presc = 0;
    int          m_snap = 0;
    bit          m_lap = 1'b0;
    bit          m_wrap = 1'b0;
    bit          m_running = 1'b0;
    logic [15:0] m_digit = '0;
    logic [2:0]  h_ss = '0, h_cl = '0, h_lp = '0;
    bit          p_ss, p_cl, p_lp, m_tick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = S_IDLE; m_cnt = 0; m_presc = 0; m_snap = 0;
            m_lap = 0; m_wrap = 0; m_running = 0; m_digit = '0;
            h_ss = '0; h_cl = '0; h_lp = '0;
        end else begin
            // A rise seen two samples back but not three back is a press.
            p_ss = h_ss[1] & ~h_ss[2];
            p_cl = h_cl[1] & ~h_cl[2];
            p_lp = h_lp[1] & ~h_lp[2];
            h_ss = {h_ss[1:0], start_stop};
            h_cl = {h_cl[1:0], clear};
            h_lp = {h_lp[1:0], lap};
            m_tick  = (m_st == S_RUN) && (m_presc == DIV - 1);
            m_digit = to_bcd(m_lap ? m_snap : m_cnt);
            m_wrap  = m_tick && (m_cnt == 5999);
            case (m_st)
                S_IDLE: begin
                    if (p_cl) begin m_cnt = 0; m_presc = 0; m_snap = 0; m_lap = 0; end
                    else if (p_ss) m_st = S_RUN;
                end
                S_RUN: begin
                    m_presc = (m_presc + 1) % DIV;
                    if (p_lp) begin
                        if (!m_lap) m_snap = m_cnt;
                        m_lap = !m_lap;
                    end
                    if (m_tick) m_cnt = (m_cnt + 1) % 6000;
                    if (p_ss) m_st = S_PAUSE;
                end
                default: begin
                    if (p_cl) begin
                        m_st = S_IDLE; m_cnt = 0; m_presc = 0; m_snap = 0; m_lap = 0;
                    end else begin
                        if (p_lp) m_lap = 0;
                        if (p_ss) m_st = S_RUN;
                    end
                end
            endcase
            m_running = (m_st == S_RUN);
        end
    end

    always @(negedge clk) begin
        check("digit",      digit,              m_digit);
        check("running",    16'(running),       16'(m_running));
        check("lap_active", 16'(lap_active),    16'(m_lap));
        check("wrap",       16'(wrap),          16'(m_wrap));
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_running(input logic want, input string tag);
        for (int i = 0; i < 20 && running !== want; i++) cycles(1);
        check(tag, 16'(running), 16'(want));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(5);
    endtask

    initial begin
        #2 rst = 1'b1;
        cycles(2);
        check("rst_digit", digit, 16'h0000);
        rst = 1'b0;
        cycles(100);
        check("idle_digit", digit, 16'h0000);
        check("idle_running", 16'(running), 16'h0000);

        // Run from 00.00 to 01.00, then on through the rollover.
        start_stop = 1'b1;
        wait_running(1'b1, "run_entry");
        start_stop = 1'b0;
        cycles(1001);
        check("one_sec", digit, 16'h0100);
        for (int i = 0; i < 60000 && !wrap; i++) cycles(1);
        check("wrap_rise", 16'(wrap), 16'h0001);
        check("wrap_prev_digit", digit, 16'h5999);
        cycles(1);
        check("wrap_fall", 16'(wrap), 16'h0000);
        check("wrap_digit", digit, 16'h0000);
        check("wrap_running", 16'(running), 16'h0001);

        // Pause at 00.37 with prescaler at 6, then resume.
        do_reset();
        start_stop = 1'b1;
        wait_running(1'b1, "run_entry2");
        start_stop = 1'b0;
        cycles(373);
        start_stop = 1'b1;
        cycles(3);
        check("paused", 16'(running), 16'h0000);
        start_stop = 1'b0;
        cycles(500);
        check("pause_hold", digit, 16'h0037);
        start_stop = 1'b1;
        cycles(3);
        check("resumed", 16'(running), 16'h0001);
        start_stop = 1'b0;
        cycles(4);
        check("resume_pre_tick", digit, 16'h0037);
        cycles(1);
        check("resume_tick", digit, 16'h0038);

        // Lap at 00.12, second lap 200 cycles later.
        do_reset();
        start_stop = 1'b1;
        wait_running(1'b1, "run_entry3");
        start_stop = 1'b0;
        cycles(122);
        lap = 1'b1;
        cycles(3);
        check("lap_on", 16'(lap_active), 16'h0001);
        cycles(1);
        check("lap_frozen", digit, 16'h0012);
        lap = 1'b0;
        cycles(100);
        check("lap_still_frozen", digit, 16'h0012);
        cycles(96);
        lap = 1'b1;
        cycles(3);
        check("lap_off", 16'(lap_active), 16'h0000);
        cycles(1);
        check("lap_release", digit, 16'h0032);
        lap = 1'b0;

        // Clear ignored in RUN; clear beats start_stop in PAUSE.
        clear = 1'b1;
        cycles(5);
        check("clear_in_run", 16'(running), 16'h0001);
        clear = 1'b0;
        cycles(5);
        start_stop = 1'b1;
        wait_running(1'b0, "pause_entry");
        start_stop = 1'b0;
        cycles(3);
        clear = 1'b1;
        start_stop = 1'b1;
        cycles(4);
        check("clr_ss_digit", digit, 16'h0000);
        check("clr_ss_running", 16'(running), 16'h0000);
        check("clr_ss_lap", 16'(lap_active), 16'h0000);
        clear = 1'b0;
        start_stop = 1'b0;
        cycles(5);

        // Random button activity with occasional mid-run resets.
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                rst = 1'b1;
                cycles($urandom_range(1, 3));
                rst = 1'b0;
            end else if (r < 45) begin
                start_stop = ~start_stop;
            end else if (r < 70) begin
                lap = ~lap;
            end else begin
                clear = ~clear;
            end
            cycles($urandom_range(1, 25));
        end
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
